pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_if.sv | 46 ++++
 rtl/pipe_stage_reg.sv | 88 ++++++++
 tb/tb_pipe_stage_reg.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Bundle of control, payload and status signals between a pipeline stage and
// its boundary register. The upstream stage drives through master; the register is the slave.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int TNEW_W = 3,
    parameter int FLAG_W = 2,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_ins;
    logic [REG_W-1:0]  in_target;
    logic [TNEW_W-1:0] in_tnew;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_wdata;
    logic [DATA_W-1:0] in_pc;
    logic [FLAG_W-1:0] in_flags;

    logic              out_valid;
    logic [DATA_W-1:0] out_ins;
    logic [REG_W-1:0]  out_target;
    logic [TNEW_W-1:0] out_tnew;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_wdata;
    logic [DATA_W-1:0] out_pc;
    logic [FLAG_W-1:0] out_flags;
    logic              fwd_ok;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output stall, flush, in_valid, in_ins, in_target, in_tnew,
               in_alu, in_wdata, in_pc, in_flags,
        input  out_valid, out_ins, out_target, out_tnew, out_alu,
               out_wdata, out_pc, out_flags, fwd_ok, stall_cnt, bubble_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_ins, in_target, in_tnew,
               in_alu, in_wdata, in_pc, in_flags,
        output out_valid, out_ins, out_target, out_tnew, out_alu,
               out_wdata, out_pc, out_flags, fwd_ok, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall/flush, valid bit,
// T_new countdown, forwarding eligibility and saturating perf counters.
module pipe_stage_reg #(
    parameter int DATA_W           = 32,
    parameter int REG_W            = 5,
    parameter int TNEW_W           = 3,
    parameter int FLAG_W           = 2,
    parameter int TNEW_DEC         = 1,
    parameter int KEEP_PC_ON_FLUSH = 1,
    parameter int CNT_W            = 16
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_reg_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] ins;
        logic [REG_W-1:0]  target;
        logic [TNEW_W-1:0] tnew;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] pc;
        logic [FLAG_W-1:0] flags;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_t            stage_q;
    stage_t            load_d;
    stage_t            bubble_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic [TNEW_W-1:0] tnew_load;

    // T_new counts down as the instruction advances one stage, never below zero.
    assign tnew_load = (TNEW_DEC != 0 && bus.in_tnew != '0) ? bus.in_tnew - 1'b1
                                                             : bus.in_tnew;

    assign load_d = '{valid:  bus.in_valid,
                      ins:    bus.in_ins,
                      target: bus.in_target,
                      tnew:   tnew_load,
                      alu:    bus.in_alu,
                      wdata:  bus.in_wdata,
                      pc:     bus.in_pc,
                      flags:  bus.in_flags};

    always_comb begin
        bubble_d    = '0;
        bubble_d.pc = (KEEP_PC_ON_FLUSH != 0) ? bus.in_pc : '0;
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would let later statements see new values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q      <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (bus.flush) begin
            stage_q <= bubble_d;
            if (bubble_cnt_q != CNT_MAX) bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end else if (bus.stall) begin
            if (stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + 1'b1;
        end else begin
            stage_q <= load_d;
            if (!bus.in_valid && bubble_cnt_q != CNT_MAX)
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign bus.out_valid  = stage_q.valid;
    assign bus.out_ins    = stage_q.ins;
    assign bus.out_target = stage_q.target;
    assign bus.out_tnew   = stage_q.tnew;
    assign bus.out_alu    = stage_q.alu;
    assign bus.out_wdata  = stage_q.wdata;
    assign bus.out_pc     = stage_q.pc;
    assign bus.out_flags  = stage_q.flags;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;

    // Derived only from registered state, so no in_* reaches an output combinationally.
    assign bus.fwd_ok = stage_q.valid && stage_q.target != '0 && stage_q.tnew == '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two configurations driven in lockstep, checked
// against a behavioural model after directed and random steps.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, in_valid;
    logic [31:0] in_ins, in_alu, in_wdata, in_pc;
    logic [4:0]  in_target;
    logic [2:0]  in_tnew;
    logic [1:0]  in_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if bus_a ();
    pipe_stage_reg_if #(.CNT_W(2)) bus_b ();

    assign bus_a.stall = stall;         assign bus_b.stall = stall;
    assign bus_a.flush = flush;         assign bus_b.flush = flush;
    assign bus_a.in_valid = in_valid;   assign bus_b.in_valid = in_valid;
    assign bus_a.in_ins = in_ins;       assign bus_b.in_ins = in_ins;
    assign bus_a.in_target = in_target; assign bus_b.in_target = in_target;
    assign bus_a.in_tnew = in_tnew;     assign bus_b.in_tnew = in_tnew;
    assign bus_a.in_alu = in_alu;       assign bus_b.in_alu = in_alu;
    assign bus_a.in_wdata = in_wdata;   assign bus_b.in_wdata = in_wdata;
    assign bus_a.in_pc = in_pc;         assign bus_b.in_pc = in_pc;
    assign bus_a.in_flags = in_flags;   assign bus_b.in_flags = in_flags;

    pipe_stage_reg dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    pipe_stage_reg #(.TNEW_DEC(0), .KEEP_PC_ON_FLUSH(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    typedef struct {
        longint unsigned valid, ins, target, tnew, alu, wdata, pc, flags;
        longint unsigned scnt, bcnt;
    } model_t;

    model_t ma, mb;

    function automatic model_t model_next(model_t m, bit dec, bit keep, longint unsigned cmax);
        model_t n = m;
        longint unsigned t;
        if (flush) begin
            n.valid = 0; n.ins = 0; n.target = 0; n.tnew = 0;
            n.alu = 0; n.wdata = 0; n.flags = 0;
            n.pc = keep ? longint'(in_pc) : 0;
            if (n.bcnt < cmax) n.bcnt = n.bcnt + 1;
        end else if (stall) begin
            if (n.scnt < cmax) n.scnt = n.scnt + 1;
        end else begin
            t = longint'(in_tnew);
            if (dec && t > 0) t = t - 1;
            n.valid = longint'(in_valid); n.ins = longint'(in_ins);
            n.target = longint'(in_target); n.tnew = t;
            n.alu = longint'(in_alu); n.wdata = longint'(in_wdata);
            n.pc = longint'(in_pc); n.flags = longint'(in_flags);
            if (!in_valid && n.bcnt < cmax) n.bcnt = n.bcnt + 1;
        end
        return n;
    endfunction

    task automatic chk(string tag, longint unsigned obs, longint unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(string tag);
        chk({tag, ".a.valid"},  longint'(bus_a.out_valid),  ma.valid);
        chk({tag, ".a.ins"},    longint'(bus_a.out_ins),    ma.ins);
        chk({tag, ".a.target"}, longint'(bus_a.out_target), ma.target);
        chk({tag, ".a.tnew"},   longint'(bus_a.out_tnew),   ma.tnew);
        chk({tag, ".a.alu"},    longint'(bus_a.out_alu),    ma.alu);
        chk({tag, ".a.wdata"},  longint'(bus_a.out_wdata),  ma.wdata);
        chk({tag, ".a.pc"},     longint'(bus_a.out_pc),     ma.pc);
        chk({tag, ".a.flags"},  longint'(bus_a.out_flags),  ma.flags);
        chk({tag, ".a.fwd"},    longint'(bus_a.fwd_ok),
            longint'(ma.valid != 0 && ma.target != 0 && ma.tnew == 0));
        chk({tag, ".a.scnt"},   longint'(bus_a.stall_cnt),  ma.scnt);
        chk({tag, ".a.bcnt"},   longint'(bus_a.bubble_cnt), ma.bcnt);
    endtask

    task automatic check_b(string tag);
        chk({tag, ".b.valid"},  longint'(bus_b.out_valid),  mb.valid);
        chk({tag, ".b.ins"},    longint'(bus_b.out_ins),    mb.ins);
        chk({tag, ".b.target"}, longint'(bus_b.out_target), mb.target);
        chk({tag, ".b.tnew"},   longint'(bus_b.out_tnew),   mb.tnew);
        chk({tag, ".b.alu"},    longint'(bus_b.out_alu),    mb.alu);
        chk({tag, ".b.wdata"},  longint'(bus_b.out_wdata),  mb.wdata);
        chk({tag, ".b.pc"},     longint'(bus_b.out_pc),     mb.pc);
        chk({tag, ".b.flags"},  longint'(bus_b.out_flags),  mb.flags);
        chk({tag, ".b.fwd"},    longint'(bus_b.fwd_ok),
            longint'(mb.valid != 0 && mb.target != 0 && mb.tnew == 0));
        chk({tag, ".b.scnt"},   longint'(bus_b.stall_cnt),  mb.scnt);
        chk({tag, ".b.bcnt"},   longint'(bus_b.bubble_cnt), mb.bcnt);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(string tag);
        @(posedge clk);
        ma = model_next(ma, 1'b1, 1'b1, 64'hFFFF);
        mb = model_next(mb, 1'b0, 1'b0, 64'h3);
        #1;
        check_a(tag);
        check_b(tag);
        @(negedge clk);
    endtask

    task automatic load(logic v, logic [31:0] ins, logic [4:0] tgt, logic [2:0] tn,
                        logic [31:0] alu, logic [31:0] pc);
        stall = 0; flush = 0; in_valid = v; in_ins = ins; in_target = tgt;
        in_tnew = tn; in_alu = alu; in_wdata = alu ^ 32'h5A5A_5A5A; in_pc = pc;
        in_flags = tgt[1:0];
    endtask

    task automatic randomize_inputs();
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_ins = $urandom; in_alu = $urandom; in_wdata = $urandom; in_pc = $urandom;
        in_target = 5'($urandom); in_tnew = 3'($urandom); in_flags = 2'($urandom);
    endtask

    task automatic async_reset_pulse(string tag);
        #2 reset = 1'b1;
        #1;
        ma = '{default: 0};
        mb = '{default: 0};
        check_a(tag);
        check_b(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 0; flush = 0;
        load(1'b0, '0, '0, '0, '0, '0);
        ma = '{default: 0};
        mb = '{default: 0};
        #1;
        check_a("reset");
        check_b("reset");
        @(negedge clk);
        reset = 1'b0;

        load(1'b1, 32'h014B_4820, 5'd9, 3'd2, 32'h1111_0000, 32'h3000);
        step("load1");
        chk("load1.tnew_is_1", longint'(bus_a.out_tnew), 1);
        chk("load1.pc", longint'(bus_a.out_pc), 64'h3000);
        chk("load1.fwd_off", longint'(bus_a.fwd_ok), 0);

        load(1'b1, 32'h014B_4820, 5'd9, 3'd1, 32'h1111_0004, 32'h3004);
        step("load2");
        chk("load2.fwd_on", longint'(bus_a.fwd_ok), 1);

        load(1'b1, 32'h0000_0020, 5'd3, 3'd0, 32'h2222_0000, 32'h3008);
        step("tnew0");
        chk("tnew0.no_wrap", longint'(bus_a.out_tnew), 0);

        load(1'b1, 32'h8C22_0000, 5'd2, 3'd3, 32'hDEAD_BEEF, 32'h300C);
        step("alu_load");
        chk("nodec.tnew3", longint'(bus_b.out_tnew), 3);

        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            stall = 1'b1;
            step("stall");
        end
        chk("stall.alu_held", longint'(bus_a.out_alu), 64'hDEAD_BEEF);
        chk("stall.cnt3", longint'(bus_a.stall_cnt), 3);

        randomize_inputs();
        in_pc = 32'h3010; stall = 1'b1; flush = 1'b1;
        step("flush");
        chk("flush.pc_keep", longint'(bus_a.out_pc), 64'h3010);
        chk("flush.pc_clear", longint'(bus_b.out_pc), 0);
        chk("flush.bcnt1", longint'(bus_a.bubble_cnt), 1);

        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            randomize_inputs();
            stall = 1'b1;
            step("stall_sat");
        end
        chk("stall_sat.cnt_w2", longint'(bus_b.stall_cnt), 3);

        load(1'b1, 32'h0123_4567, 5'd7, 3'd1, 32'hCAFE_F00D, 32'h4000);
        step("pre_reset");
        async_reset_pulse("async_reset1");

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            stall = 1'($urandom_range(0, 3) == 0);
            flush = 1'($urandom_range(0, 7) == 0);
            step("random");
        end
        async_reset_pulse("async_reset2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
